// File: rtl/team_06_audio_pkg.sv
// Shared types and helpers for the team_06 audio blocks: echo FSM states,
// default widths and the weighted-mix arithmetic used by the echo mixer.
package team_06_audio_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int DELAY_W_DEF = 13;
    localparam int GAIN_W_DEF  = 3;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        MIX,
        WR_REQ,
        OUT
    } echo_state_t;

    // Weighted blend (a*(2^gain_w - g) + p*g) >> gain_w.
    // Operands arrive zero-extended to 32 bits, which covers DATA_W+GAIN_W+1.
    function automatic logic [31:0] weighted_mix(
        input logic [31:0] a,
        input logic [31:0] p,
        input logic [31:0] g,
        input int          gain_w
    );
        logic [31:0] wa;
        logic [31:0] wp;
        wa = a * ((32'd1 << gain_w) - g);
        wp = p * g;
        return (wa + wp) >> gain_w;
    endfunction

endpackage

// File: rtl/team_06_echo_mixer.sv
// Combinational weighted mix of the current and delayed sample, with a result
// register loaded while the echo FSM sits in its MIX state.
module team_06_echo_mixer
    import team_06_audio_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int GAIN_W = GAIN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] audio,
    input  logic [DATA_W-1:0] past,
    input  logic [GAIN_W-1:0] gain,
    output logic [DATA_W-1:0] mix_now,
    output logic [DATA_W-1:0] mix_q
);

    // The weights sum to 2^GAIN_W, so the shifted result always fits DATA_W.
    assign mix_now = DATA_W'(weighted_mix(32'(audio), 32'(past), 32'(gain), GAIN_W));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mix_q <= '0;
        end else if (load) begin
            mix_q <= mix_now;
        end
    end

endmodule

// File: rtl/team_06_echo_engine.sv
// Handshaked echo/delay effect: reads the sample delay_samples ago from SRAM,
// blends it with the new sample and writes the delay-line sample back.
module team_06_echo_engine
    import team_06_audio_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int GAIN_W  = GAIN_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  audio_in,
    input  logic               echo_en,
    input  logic               feedback_mode,
    input  logic [DELAY_W-1:0] delay_samples,
    input  logic [GAIN_W-1:0]  gain,
    output logic [DELAY_W-1:0] offset,
    output logic               mem_rd_req,
    input  logic               mem_rd_ack,
    input  logic [DATA_W-1:0]  past_output,
    output logic               mem_wr_req,
    input  logic               mem_wr_ack,
    output logic [DATA_W-1:0]  save_audio,
    output logic [DATA_W-1:0]  echo_out,
    output logic               echo_valid,
    output logic               busy,
    output logic               overrun,
    output logic               mem_miss
);

    localparam int                 TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [DELAY_W-1:0] FILL_MAX = '1;

    echo_state_t        state;
    echo_state_t        state_nxt;
    logic [TMR_W-1:0]   timer;
    logic [DELAY_W-1:0] fill_cnt;
    logic [DELAY_W-1:0] eff_fill;
    logic [DATA_W-1:0]  audio_lat;
    logic [DATA_W-1:0]  past_reg;
    logic [GAIN_W-1:0]  gain_lat;
    logic               fb_lat;
    logic               en_lat;
    logic [DATA_W-1:0]  mix_now;
    logic [DATA_W-1:0]  mix_q;

    logic accept;
    logic rd_done;
    logic rd_miss;
    logic wr_done;
    logic wr_miss;

    team_06_echo_mixer #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W)
    ) u_mixer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == MIX),
        .audio   (audio_lat),
        .past    (past_reg),
        .gain    (gain_lat),
        .mix_now (mix_now),
        .mix_q   (mix_q)
    );

    // A new delay value restarts warm-up, so the accept decision must already
    // see the cleared fill count rather than the stale one.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rd_done   = 1'b0;
        rd_miss   = 1'b0;
        wr_done   = 1'b0;
        wr_miss   = 1'b0;
        eff_fill  = (delay_samples != offset) ? '0 : fill_cnt;

        case (state)
            IDLE: begin
                if (sample_valid) begin
                    accept = 1'b1;
                    if (!echo_en || delay_samples == '0 || eff_fill < delay_samples) begin
                        state_nxt = MIX;
                    end else begin
                        state_nxt = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (mem_rd_ack) begin
                    rd_done   = 1'b1;
                    state_nxt = MIX;
                end else if (timer == TMR_LAST) begin
                    rd_miss   = 1'b1;
                    state_nxt = MIX;
                end
            end
            MIX: begin
                state_nxt = en_lat ? WR_REQ : OUT;
            end
            WR_REQ: begin
                if (mem_wr_ack) begin
                    wr_done   = 1'b1;
                    state_nxt = OUT;
                end else if (timer == TMR_LAST) begin
                    wr_miss   = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_rd_req = (state == RD_REQ);
    assign mem_wr_req = (state == WR_REQ);
    assign busy       = (state != IDLE);

    // State register plus all datapath latches; past_reg defaults to the dry
    // sample at accept so a read timeout needs no extra handling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            fill_cnt   <= '0;
            offset     <= '0;
            audio_lat  <= '0;
            past_reg   <= '0;
            gain_lat   <= '0;
            fb_lat     <= 1'b0;
            en_lat     <= 1'b0;
            save_audio <= '0;
            echo_out   <= '0;
            echo_valid <= 1'b0;
            overrun    <= 1'b0;
            mem_miss   <= 1'b0;
        end else begin
            state      <= state_nxt;
            echo_valid <= (state == OUT);
            overrun    <= sample_valid && (state != IDLE);
            mem_miss   <= rd_miss || wr_miss;

            if ((state == RD_REQ || state == WR_REQ) && state_nxt == state) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end

            if (accept) begin
                audio_lat <= audio_in;
                past_reg  <= audio_in;
                gain_lat  <= gain;
                fb_lat    <= feedback_mode;
                en_lat    <= echo_en;
                offset    <= delay_samples;
                if (delay_samples != offset) begin
                    fill_cnt <= '0;
                end
            end

            if (rd_done) begin
                past_reg <= past_output;
            end

            if (state == MIX && en_lat) begin
                save_audio <= fb_lat ? mix_now : audio_lat;
            end

            if (wr_done && fill_cnt != FILL_MAX) begin
                fill_cnt <= fill_cnt + 1'b1;
            end

            if (state == OUT) begin
                echo_out <= mix_q;
            end
        end
    end

endmodule

// File: tb/tb_team_06_echo_engine.sv
// Bench for team_06_echo_engine: directed vector table, multi-cycle corner
// sequences and a randomized run against a delay-line reference model.
module tb_team_06_echo_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [7:0]  audio_in;
    logic        echo_en;
    logic        feedback_mode;
    logic [12:0] delay_samples;
    logic [2:0]  gain;
    logic [12:0] offset;
    logic        mem_rd_req;
    logic        mem_rd_ack;
    logic [7:0]  past_output;
    logic        mem_wr_req;
    logic        mem_wr_ack;
    logic [7:0]  save_audio;
    logic [7:0]  echo_out;
    logic        echo_valid;
    logic        busy;
    logic        overrun;
    logic        mem_miss;

    int checks = 0;
    int errors = 0;

    logic [7:0] sram[$];

    team_06_echo_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_valid  (sample_valid),
        .audio_in      (audio_in),
        .echo_en       (echo_en),
        .feedback_mode (feedback_mode),
        .delay_samples (delay_samples),
        .gain          (gain),
        .offset        (offset),
        .mem_rd_req    (mem_rd_req),
        .mem_rd_ack    (mem_rd_ack),
        .past_output   (past_output),
        .mem_wr_req    (mem_wr_req),
        .mem_wr_ack    (mem_wr_ack),
        .save_audio    (save_audio),
        .echo_out      (echo_out),
        .echo_valid    (echo_valid),
        .busy          (busy),
        .overrun       (overrun),
        .mem_miss      (mem_miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [12:0] d;
        logic [2:0]  g;
        bit          fb;
        bit          en;
        logic [7:0]  exp_echo;
        logic [7:0]  exp_save;
        int          exp_lat;
    } vec_t;

    task automatic check_output(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drives one sample and plays SRAM: rd_wait/wr_wait request cycles pass
    // before the ack (-1 = never ack). ov_at injects a sample while busy.
    task automatic apply_stimulus(
        input  logic [7:0]  a,
        input  logic [12:0] d,
        input  logic [2:0]  g,
        input  bit          fb,
        input  bit          en,
        input  int          rd_wait,
        input  int          wr_wait,
        input  int          ov_at,
        output logic [7:0]  eo,
        output logic [7:0]  sa,
        output int          lat,
        output int          rd_cycles,
        output int          miss_cnt,
        output int          ov_cnt,
        output logic [12:0] rd_off
    );
        int wr_seen;
        int idx;
        eo = '0; sa = '0; lat = -1; rd_cycles = 0; miss_cnt = 0; ov_cnt = 0;
        rd_off = '0; wr_seen = 0;
        @(negedge clk);
        audio_in = a; delay_samples = d; gain = g; feedback_mode = fb;
        echo_en = en; sample_valid = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            sample_valid = 1'b0; mem_rd_ack = 1'b0; mem_wr_ack = 1'b0;
            if (c == 1) echo_en = !en;
            if (overrun) ov_cnt++;
            if (mem_miss) miss_cnt++;
            if (echo_valid) begin
                eo  = echo_out;
                lat = c;
                break;
            end
            if (c == ov_at) begin
                sample_valid = 1'b1;
                audio_in = 8'd7;
            end
            if (mem_rd_req) begin
                rd_cycles++;
                rd_off = offset;
                if (rd_wait >= 0 && rd_cycles > rd_wait) begin
                    mem_rd_ack = 1'b1;
                    idx = sram.size() - int'(offset);
                    past_output = (idx >= 0 && idx < sram.size()) ? sram[idx] : 8'h00;
                end
            end
            if (mem_wr_req) begin
                wr_seen++;
                if (wr_wait >= 0 && wr_seen > wr_wait) begin
                    mem_wr_ack = 1'b1;
                    sa = save_audio;
                    sram.push_back(save_audio);
                end
            end
        end
        if (lat < 0) check_output("echo_valid_seen", 0, 1);
    endtask

    vec_t        vecs[13];
    logic [7:0]  eo, sa;
    int          lat, rdc, missc, ovc;
    logic [12:0] roff;

    // Reference model state: delay-line history of intended writes
    int          m_hist[$];
    int          m_fill, m_off, p, mix, w, rw, ww, exp_lat, cur_d;
    bit          dry, fb, en;
    logic [7:0]  a;
    logic [2:0]  g;

    initial begin
        rst_n = 1'b0; sample_valid = 1'b0; audio_in = '0; echo_en = 1'b0;
        feedback_mode = 1'b0; delay_samples = '0; gain = '0;
        mem_rd_ack = 1'b0; mem_wr_ack = 1'b0; past_output = '0;

        vecs[0]  = '{8'd100, 13'd1, 3'd3, 1'b0, 1'b1, 8'd100, 8'd100, 4};
        vecs[1]  = '{8'd200, 13'd1, 3'd4, 1'b0, 1'b1, 8'd150, 8'd200, 5};
        vecs[2]  = '{8'd240, 13'd1, 3'd7, 1'b0, 1'b1, 8'd205, 8'd240, 5};
        vecs[3]  = '{8'd80,  13'd1, 3'd2, 1'b1, 1'b1, 8'd120, 8'd120, 5};
        vecs[4]  = '{8'd50,  13'd1, 3'd0, 1'b0, 1'b0, 8'd50,  8'd0,   3};
        vecs[5]  = '{8'd255, 13'd1, 3'd7, 1'b0, 1'b1, 8'd136, 8'd255, 5};
        vecs[6]  = '{8'd255, 13'd1, 3'd0, 1'b0, 1'b1, 8'd255, 8'd255, 5};
        vecs[7]  = '{8'd255, 13'd1, 3'd7, 1'b1, 1'b1, 8'd255, 8'd255, 5};
        vecs[8]  = '{8'd0,   13'd1, 3'd7, 1'b0, 1'b1, 8'd223, 8'd0,   5};
        vecs[9]  = '{8'd10,  13'd2, 3'd7, 1'b0, 1'b1, 8'd10,  8'd10,  4};
        vecs[10] = '{8'd20,  13'd2, 3'd7, 1'b0, 1'b1, 8'd20,  8'd20,  4};
        vecs[11] = '{8'd30,  13'd2, 3'd4, 1'b0, 1'b1, 8'd20,  8'd30,  5};
        vecs[12] = '{8'd99,  13'd0, 3'd7, 1'b0, 1'b1, 8'd99,  8'd99,  4};

        repeat (3) @(negedge clk);
        check_output("reset_outputs",
            longint'({offset, save_audio, echo_out, mem_rd_req, mem_wr_req,
                      echo_valid, busy, overrun, mem_miss}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].d, vecs[i].g, vecs[i].fb, vecs[i].en,
                           0, 0, -1, eo, sa, lat, rdc, missc, ovc, roff);
            check_output($sformatf("vec%0d_echo", i), eo, vecs[i].exp_echo);
            check_output($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check_output($sformatf("vec%0d_read", i), rdc > 0, vecs[i].exp_lat == 5);
            if (vecs[i].en) check_output($sformatf("vec%0d_save", i), sa, vecs[i].exp_save);
        end

        // Warm-up: four dry samples, then the fifth goes to memory
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(8'd100, 13'd4, 3'd5, 1'b0, 1'b1, 0, 0, -1,
                           eo, sa, lat, rdc, missc, ovc, roff);
            check_output($sformatf("warm%0d_echo", i), eo, 100);
            check_output($sformatf("warm%0d_read", i), rdc > 0, i == 4);
        end
        check_output("warm_offset", roff, 4);

        // Read timeout
        apply_stimulus(8'd77, 13'd4, 3'd7, 1'b0, 1'b1, -1, 0, -1,
                       eo, sa, lat, rdc, missc, ovc, roff);
        check_output("rd_timeout_req_cycles", rdc, 16);
        check_output("rd_timeout_miss", missc, 1);
        check_output("rd_timeout_echo", eo, 77);
        check_output("rd_timeout_latency", lat, 20);

        // Write timeout keeps the fill count, so the next sample is still dry
        apply_stimulus(8'd33, 13'd1, 3'd3, 1'b0, 1'b1, 0, -1, -1,
                       eo, sa, lat, rdc, missc, ovc, roff);
        check_output("wr_timeout_miss", missc, 1);
        check_output("wr_timeout_echo", eo, 33);
        check_output("wr_timeout_latency", lat, 19);
        apply_stimulus(8'd44, 13'd1, 3'd5, 1'b0, 1'b1, 0, 0, -1,
                       eo, sa, lat, rdc, missc, ovc, roff);
        check_output("after_wr_timeout_read", rdc, 0);
        check_output("after_wr_timeout_echo", eo, 44);

        // Overrun while waiting for a read
        apply_stimulus(8'd60, 13'd1, 3'd0, 1'b0, 1'b1, 2, 0, 1,
                       eo, sa, lat, rdc, missc, ovc, roff);
        check_output("overrun_pulses", ovc, 1);
        check_output("overrun_echo", eo, 60);
        check_output("overrun_latency", lat, 7);
        ovc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (echo_valid || busy) ovc++;
        end
        check_output("overrun_dropped", ovc, 0);

        // Reset in the middle of a read request
        @(negedge clk);
        audio_in = 8'd90; delay_samples = 13'd1; echo_en = 1'b1; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        check_output("pre_reset_rd_req", mem_rd_req, 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("mid_reset_outputs",
            longint'({offset, save_audio, echo_out, mem_rd_req, mem_wr_req,
                      echo_valid, busy, overrun, mem_miss}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post_reset_rd_req", mem_rd_req, 0);
        check_output("post_reset_busy", busy, 0);

        // Randomized run against the delay-line model
        m_fill = 0; m_off = 0; cur_d = 1;
        for (int i = 0; i < 60; i++) begin
            if (i == 0 || $urandom_range(0, 9) == 0) cur_d = int'($urandom_range(1, 3));
            a  = 8'($urandom_range(0, 255));
            g  = 3'($urandom_range(0, 7));
            fb = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 6) != 0);
            rw = int'($urandom_range(0, 3));
            ww = int'($urandom_range(0, 3));
            if (cur_d != m_off) m_fill = 0;
            m_off = cur_d;
            dry = !en || m_fill < cur_d;
            p   = dry ? int'(a) : m_hist[m_hist.size() - cur_d];
            mix = (int'(a) * (8 - int'(g)) + p * int'(g)) / 8;
            exp_lat = (dry ? (en ? 4 : 3) : 5 + rw) + (en ? ww : 0);
            apply_stimulus(a, 13'(cur_d), g, fb, en, rw, ww, -1,
                           eo, sa, lat, rdc, missc, ovc, roff);
            check_output($sformatf("rand%0d_echo", i), eo, mix);
            check_output($sformatf("rand%0d_latency", i), lat, exp_lat);
            check_output($sformatf("rand%0d_read", i), rdc > 0, !dry);
            if (en) begin
                w = fb ? mix : int'(a);
                m_hist.push_back(w);
                if (m_fill < 8191) m_fill++;
                check_output($sformatf("rand%0d_save", i), sa, w);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/team_06_echo_engine.md
Name: team_06_echo_engine

Overview:
- Parametrised, handshaked echo/delay effect; successor to the fixed 8-bit, fixed-8000-offset, 50/50 echo.
- Sits between the audio sample source and the SRAM read/write arbiter.
- Per input sample: fetches the sample from delay_samples ago, mixes it with a programmable weight, then writes the delay-line sample back.
- Supports feed-forward (single echo) and feedback (repeating, decaying echo) modes, with warm-up and timeout protection.

Parameters:
- DATA_W, 8, audio sample width (unsigned PCM).
- DELAY_W, 13, width of delay/offset value (max delay 2^DELAY_W-1 samples).
- GAIN_W, 3, width of echo weight; weight = gain/2^GAIN_W.
- TIMEOUT, 16, max cycles to wait for any memory ack.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sample_valid  in  1  one-cycle strobe: audio_in holds a new sample
- audio_in  in  DATA_W  incoming audio sample
- echo_en  in  1  0 = bypass (no memory traffic), 1 = echo active
- feedback_mode  in  1  0 = write audio_in to memory, 1 = write echo_out to memory
- delay_samples  in  DELAY_W  echo distance in samples; sampled at sample accept
- gain  in  GAIN_W  echo weight g
- offset  out  DELAY_W  registered copy of delay_samples for the memory controller
- mem_rd_req  out  1  read request, held until mem_rd_ack
- mem_rd_ack  in  1  read data valid on past_output this cycle
- past_output  in  DATA_W  sample returned from memory
- mem_wr_req  out  1  write request, held until mem_wr_ack
- mem_wr_ack  in  1  write accepted
- save_audio  out  DATA_W  data written to SRAM, stable while mem_wr_req=1
- echo_out  out  DATA_W  processed sample
- echo_valid  out  1  one-cycle strobe when echo_out updates
- busy  out  1  FSM not in IDLE
- overrun  out  1  one-cycle pulse: sample_valid arrived while busy; that sample is dropped
- mem_miss  out  1  one-cycle pulse: read timed out; dry sample used

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0, FSM=IDLE, fill_cnt=0, timer=0. Reset mid-transaction aborts immediately, with no pending requests after reset.
- FSM states: IDLE, RD_REQ, MIX, WR_REQ, OUT.
- IDLE + sample_valid: latch audio_in, delay_samples (to offset), gain, feedback_mode.
  - If echo_en=0, or delay_samples=0, or fill_cnt<delay_samples: go to MIX with past forced to audio_in (dry).
  - Otherwise go to RD_REQ.
- RD_REQ: mem_rd_req=1.
  - On mem_rd_ack: capture past_output, go to MIX.
  - If timer reaches TIMEOUT with no ack: past=dry sample, pulse mem_miss, go to MIX.
- MIX: mix = (a*(2^GAIN_W - g) + p*g) >> GAIN_W.
  - a = latched audio, p = past.
  - Intermediate width DATA_W+GAIN_W+1; truncating shift; result never exceeds 2^DATA_W-1.
  - Register the result.
- WR_REQ, entered only when echo_en=1:
  - save_audio = latched audio (feedback_mode=0) or mix (feedback_mode=1).
  - mem_wr_req=1 until mem_wr_ack.
  - On timeout, drop the write, pulse mem_miss, and do not increment fill_cnt.
  - If echo_en=0, MIX goes directly to OUT.
- OUT: echo_out<=mix, echo_valid=1 for one cycle, return to IDLE.
  - On a successful write, fill_cnt increments, saturating at 2^DELAY_W-1.
- Latency, sample_valid to echo_valid:
  - Bypass/warm-up: 3 cycles (IDLE->MIX->[WR_REQ]->OUT; 4 with a same-cycle wr_ack when echo_en=1).
  - Full path with zero-wait acks: 5 cycles.
- The next sample is accepted in the cycle after OUT.
- A delay_samples value differing from the previous latched offset clears fill_cnt (delay line restarts warm-up).
- echo_en falling: no effect on an in-flight sample. fill_cnt is retained.
- mem_rd_ack/mem_wr_ack outside their request states are ignored.

Decomposition:
- Shared package team_06_audio_pkg holds:
  - echo_state_t enum;
  - default constants for DATA_W, DELAY_W, GAIN_W;
  - a function for the weighted mix.
- One natural sub-module, team_06_echo_mixer: combinational weighted mix plus output register, parametrised on DATA_W/GAIN_W.
- The FSM, timer and fill counter stay in the top module.

Test Plan:
- Reset: hold rst_n=0 three cycles mid-RD_REQ -> all outputs 0, mem_rd_req=0 the cycle after reset.
- Warm-up: delay_samples=4, echo_en=1, feed 4 samples of 100 -> echo_out=100 each with no mem_rd_req; the 5th sample issues mem_rd_req with offset=4.
- Mix, feed-forward: g=4 (GAIN_W=3), audio_in=200, past_output=100 with immediate acks -> echo_out=150, save_audio=200, echo_valid exactly 5 cycles after sample_valid.
- Feedback mode: g=2, audio=80, past=240 -> echo_out=(80*6+240*2)>>3=120, save_audio=120.
- Timeout: never assert mem_rd_ack, TIMEOUT=16 -> mem_miss pulses after 16 request cycles, echo_out=audio_in.
- Overrun: sample_valid asserted during RD_REQ -> overrun pulses one cycle, that sample produces no echo_valid.
